uart_tx_top: RTL and testbench



---
 rtl/uart_tx_top.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_top.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_top.sv
// -----------------------------------------------------------------------------
// uart_tx_top
//
// Single-clock UART transmitter: FSM, serializer, parity generator and output
// mux in one block. The supplied clock is the bit clock; one serial bit is
// emitted per rising edge. Frame: start (0), DATA_WIDTH data bits LSB first,
// optional parity bit, stop (1).
//
// Optional feature macro: UART_TX_TWO_STOP_EN
//   defined   -> two stop bits per frame
//   undefined -> one stop bit per frame
//
// Ports:
//   clk                      bit clock, all logic on rising edge
//   rst                      synchronous, active-high reset
//   data_valid               request to send p_data (sampled only while idle)
//   p_data[DATA_WIDTH-1:0]   parallel data to transmit
//   PAR_EN                   1 = append parity bit after the data bits
//   parity_type              0 = even, 1 = odd (ignored when PAR_EN = 0)
//   Tx_out                   registered serial line, idles high
//   busy_1                   registered, high while a frame is on the line
//   serializer_enable_debug  registered, high exactly during data-bit cycles
// -----------------------------------------------------------------------------
module uart_tx_top #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  PAR_EN,
    input  logic                  parity_type,
    output logic                  Tx_out,
    output logic                  busy_1,
    output logic                  serializer_enable_debug
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;

    // Frame copy captured at the accepting edge; the line is driven only from
    // these, so the inputs are free to change while the frame is in flight.
    logic [DATA_WIDTH-1:0]   shift_p0;
    logic                    par_en_p0;
    logic                    parity_p0;

`ifdef UART_TX_TWO_STOP_EN
    logic                    stop_cnt;
`endif

    // XOR of the data bits makes the total count of ones even; inverting it
    // makes the count odd.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic                  odd);
        return (^d) ^ odd;
    endfunction

    // Outputs are registered: each branch loads the value the line must carry
    // during the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= IDLE;
            Tx_out                  <= 1'b1;
            busy_1                  <= 1'b0;
            serializer_enable_debug <= 1'b0;
            bit_cnt                 <= '0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt                <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    Tx_out                  <= 1'b1;
                    busy_1                  <= 1'b0;
                    serializer_enable_debug <= 1'b0;
                    bit_cnt                 <= '0;
                    if (data_valid) begin
                        state  <= START;
                        Tx_out <= 1'b0;
                        busy_1 <= 1'b1;
                    end
                end
                START: begin
                    state                   <= DATA;
                    Tx_out                  <= shift_p0[0];
                    serializer_enable_debug <= 1'b1;
                    bit_cnt                 <= CNT_W'(1);
                end
                DATA: begin
                    // bit_cnt counts bits already placed on the line.
                    if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                        serializer_enable_debug <= 1'b0;
                        if (par_en_p0) begin
                            state  <= PARITY;
                            Tx_out <= parity_p0;
                        end else begin
                            state  <= STOP;
                            Tx_out <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                            stop_cnt <= 1'b0;
`endif
                        end
                    end else begin
                        Tx_out  <= shift_p0[0];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    Tx_out <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                    stop_cnt <= 1'b0;
`endif
                end
                STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!stop_cnt) begin
                        stop_cnt <= 1'b1;
                        Tx_out   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        Tx_out <= 1'b1;
                        busy_1 <= 1'b0;
                    end
`else
                    state  <= IDLE;
                    Tx_out <= 1'b1;
                    busy_1 <= 1'b0;
`endif
                end
                default: begin
                    state                   <= IDLE;
                    Tx_out                  <= 1'b1;
                    busy_1                  <= 1'b0;
                    serializer_enable_debug <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: no reset, only loaded on acceptance and shifted while
    // serializing. The shifter advances in START so that bit 1 is already at
    // position 0 when the first DATA cycle needs it.
    always_ff @(posedge clk) begin
        if (state == IDLE && data_valid) begin
            shift_p0  <= p_data;
            par_en_p0 <= PAR_EN;
            parity_p0 <= calc_parity(p_data, parity_type);
        end else if (state == START || state == DATA) begin
            shift_p0 <= shift_p0 >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
module tb_uart_tx_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_valid;
    logic [7:0] p_data;
    logic       PAR_EN;
    logic       parity_type;
    logic       Tx_out;
    logic       busy_1;
    logic       serializer_enable_debug;

    int total = 0;
    int bad   = 0;

    bit exp_q[$];

    uart_tx_top #(.DATA_WIDTH(8)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .data_valid              (data_valid),
        .p_data                  (p_data),
        .PAR_EN                  (PAR_EN),
        .parity_type             (parity_type),
        .Tx_out                  (Tx_out),
        .busy_1                  (busy_1),
        .serializer_enable_debug (serializer_enable_debug)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},   Tx_out, 1'b1);
        chk({tag, "_busy"}, busy_1, 1'b0);
        chk({tag, "_sed"},  serializer_enable_debug, 1'b0);
    endtask

    // Reference frame built from the line protocol: start, data LSB first,
    // parity chosen so the ones count meets the requested sense, stop bit(s).
    task automatic build_frame(input logic [7:0] d, input bit pe, input bit pt);
        int ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) begin
            if (pt) exp_q.push_back((ones % 2) == 0);
            else    exp_q.push_back((ones % 2) == 1);
        end
        exp_q.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
        exp_q.push_back(1'b1);
`endif
    endtask

    // Offers a frame and checks every line cycle. data_valid stays high for
    // dv_n sampling edges; with scramble set, the other inputs are randomised
    // during the frame. Returns with the bench in the cycle after the frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input bit pe,
                             input bit pt, input int dv_n, input bit scramble);
        int n;
        build_frame(d, pe, pt);
        n = exp_q.size();
        data_valid  = 1'b1;
        p_data      = d;
        PAR_EN      = pe;
        parity_type = pt;
        tick();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_tx%0d", tag, k), Tx_out, exp_q[k]);
            chk($sformatf("%s_busy%0d", tag, k), busy_1, 1'b1);
            chk($sformatf("%s_sed%0d", tag, k), serializer_enable_debug,
                (k >= 1 && k <= 8));
            data_valid = (k + 1 < dv_n);
            if (scramble) begin
                p_data      = 8'($urandom);
                PAR_EN      = 1'($urandom);
                parity_type = 1'($urandom);
            end
            tick();
        end
    endtask

    initial begin
        rst         = 1'b1;
        data_valid  = 1'b0;
        p_data      = 8'h00;
        PAR_EN      = 1'b0;
        parity_type = 1'b0;

        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("idle0");

        // Directed frames.
        run_frame("np55", 8'h55, 1'b0, 1'b0, 1, 1'b0);
        chk_idle("np55_end");
        run_frame("evCC", 8'hCC, 1'b1, 1'b0, 2, 1'b0);
        chk_idle("evCC_end");
        tick();
        chk_idle("evCC_end2");
        run_frame("odAA", 8'hAA, 1'b1, 1'b1, 1, 1'b0);
        chk_idle("odAA_end");

        // Mid-frame change of p_data must not reach the line.
        data_valid  = 1'b1;
        p_data      = 8'hF0;
        PAR_EN      = 1'b0;
        parity_type = 1'b0;
        build_frame(8'hF0, 1'b0, 1'b0);
        tick();
        data_valid = 1'b0;
        p_data     = 8'hAA;
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("midF0_tx%0d", k), Tx_out, exp_q[k]);
            tick();
        end
        chk_idle("midF0_end");

        // Random frames with input noise during the frame.
        for (int r = 0; r < 8; r++) begin
            run_frame($sformatf("rnd%0d", r), 8'($urandom), 1'($urandom),
                      1'($urandom), int'($urandom_range(1, 3)), 1'b1);
            chk_idle($sformatf("rnd%0d_end", r));
            data_valid = 1'b0;
            tick();
            chk_idle($sformatf("rnd%0d_gap", r));
        end

        // Reset in the middle of a frame.
        data_valid = 1'b1;
        p_data     = 8'h00;
        PAR_EN     = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("abort_started", busy_1, 1'b1);
        tick();
        tick();
        tick();
        chk("abort_line_low", Tx_out, 1'b0);
        rst = 1'b1;
        tick();
        chk_idle("abort");
        rst = 1'b0;
        tick();
        chk_idle("abort_after");

        // Back-to-back: data_valid held; exactly one idle-high cycle between.
        run_frame("b2b1", 8'h3C, 1'b0, 1'b0, 1000, 1'b0);
        chk("b2b_gap_tx", Tx_out, 1'b1);
        chk("b2b_gap_busy", busy_1, 1'b0);
        run_frame("b2b2", 8'hA5, 1'b0, 1'b0, 6, 1'b0);
        chk_idle("b2b_end");
        tick();
        chk_idle("b2b_end2");
        tick();
        chk_idle("b2b_end3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
